// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants and types for the instruction fetch buffer.
package inst_fetch_buf_pkg;

  localparam int unsigned IF_BUF_DEPTH = 4;
  localparam int unsigned IF_BUF_PTR_W = 2;
  localparam int unsigned IF_BUF_CNT_W = 3;
  localparam int unsigned INST_ADDR_W  = 32;
  localparam int unsigned INST_W       = 32;

  // Count value at which no further fetch may be issued.
  localparam logic [IF_BUF_CNT_W-1:0] IF_BUF_FULL = 3'd4;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // Index of the stall bit that blocks handoff into IF/ID.
  localparam int unsigned STALL_IF_BIT = 1;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// Four-entry FIFO of {pc, inst} pairs feeding IF/ID; head is read
// combinationally from storage and reads as zero when empty.
module inst_fifo
  import inst_fetch_buf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  fetch_entry_t            push_data,
  input  logic                    pop,
  output logic                    valid,
  output fetch_entry_t            head,
  output logic [IF_BUF_CNT_W-1:0] count
);

  fetch_entry_t            mem [IF_BUF_DEPTH];
  logic [IF_BUF_PTR_W-1:0] rd_ptr;
  logic [IF_BUF_PTR_W-1:0] wr_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; flush empties the buffer without popping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Head presentation: zero (NOP at address 0) while empty.
  always_comb begin
    valid = (count != '0);
    head  = '0;
    if (valid) begin
      head = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: a three-state fetch FSM issues one bus request
// at a time into a four-entry FIFO that decouples the bus from IF/ID.
//
// Bus handshake: ibus_req_o/ibus_addr_o are registered and held stable from
// the cycle after issue until the cycle ibus_ack_i=1 is seen; ibus_rdata_i is
// consumed only in that ack cycle. Only one request is ever outstanding, and
// an ack seen while no request is outstanding (IDLE) is ignored.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INST_ADDR_W-1:0]  pc_i,
  input  logic                    ce_i,
  input  logic [5:0]              stall,
  input  logic                    flush,
  output logic                    stallreq_o,
  output logic                    ibus_req_o,
  output logic [INST_ADDR_W-1:0]  ibus_addr_o,
  input  logic                    ibus_ack_i,
  input  logic [INST_W-1:0]       ibus_rdata_i,
  output logic                    if_valid_o,
  output logic [INST_ADDR_W-1:0]  if_pc_o,
  output logic [INST_W-1:0]       if_inst_o,
  output fetch_state_e            dbg_state,
  output logic [IF_BUF_CNT_W-1:0] dbg_count
);

  fetch_state_e            state;
  fetch_state_e            state_n;
  logic                    req_n;
  logic [INST_ADDR_W-1:0]  addr_n;
  logic                    push;
  logic                    pop;
  logic [IF_BUF_CNT_W-1:0] count;
  fetch_entry_t            head;
  fetch_entry_t            push_data;
  logic                    unused_stall;

  // Only the IF/ID hold bit matters here; the other stall bits are for other stages.
  assign unused_stall = ^{stall[5:2], stall[0]};

  // FSM state and registered bus request; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_IDLE;
      ibus_req_o  <= 1'b0;
      ibus_addr_o <= '0;
    end else begin
      state       <= state_n;
      ibus_req_o  <= req_n;
      ibus_addr_o <= addr_n;
    end
  end

  // Next state, next bus request and FIFO push decision.
  always_comb begin
    state_n = state;
    req_n   = ibus_req_o;
    addr_n  = ibus_addr_o;
    push    = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        if (ce_i && (count < IF_BUF_FULL) && !flush) begin
          state_n = FETCH_WAIT;
          req_n   = 1'b1;
          addr_n  = pc_i;
        end else begin
          req_n   = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (ibus_ack_i) begin
          push    = !flush;
          req_n   = 1'b0;
          state_n = FETCH_IDLE;
        end else if (flush) begin
          // Request cannot be withdrawn; wait for its ack and drop the data.
          state_n = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (ibus_ack_i) begin
          req_n   = 1'b0;
          state_n = FETCH_IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = FETCH_IDLE;
      end
    endcase
  end

  // Hold the PC stage except in the cycle its word is captured.
  always_comb begin
    stallreq_o = ce_i && !((state == FETCH_WAIT) && ibus_ack_i && !flush);
  end

  // Handoff to IF/ID: pop whenever the head is valid and IF/ID is not held.
  always_comb begin
    pop            = if_valid_o && !stall[STALL_IF_BIT] && !flush;
    push_data.pc   = ibus_addr_o;
    push_data.inst = ibus_rdata_i;
  end

  inst_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .valid     (if_valid_o),
    .head      (head),
    .count     (count)
  );

  assign if_pc_o   = head.pc;
  assign if_inst_o = head.inst;
  assign dbg_state = state;
  assign dbg_count = count;

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 Reset is rst, synchronous, active-high; clock is clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pc_i  in  32  fetch address from the PC stage.
REQ-005 ce_i  in  1  PC stage chip enable; fetch is permitted only when 1.
REQ-006 stall  in  6  pipeline stall vector; stall[1]=1 blocks handoff to IF/ID.
REQ-007 flush  in  1  discards all buffered and in-flight instructions.
REQ-008 stallreq_o  out  1  requests ctrl to hold the PC stage (stall[0]).
REQ-009 ibus_req_o  out  1  instruction bus request, registered.
REQ-010 ibus_addr_o  out  32  instruction bus address, registered.
REQ-011 ibus_ack_i  in  1  bus response valid; ibus_rdata_i is valid when it is 1.
REQ-012 ibus_rdata_i  in  32  fetched instruction word.
REQ-013 if_valid_o  out  1  buffer head holds a valid instruction.
REQ-014 if_pc_o  out  32  address of the head instruction; 0 when empty.
REQ-015 if_inst_o  out  32  head instruction word; 0 (NOP) when empty.

Function
REQ-016 The buffer SHALL hold a 4-entry FIFO of {pc, inst} pairs plus a 3-state fetch FSM: IDLE, WAIT, DRAIN.
REQ-017 In IDLE, if ce_i=1, count<4 and flush=0, the FSM SHALL register ibus_req_o<=1 and ibus_addr_o<=pc_i, then go to WAIT; otherwise it SHALL remain in IDLE with ibus_req_o=0.
REQ-018 In WAIT, ibus_req_o and ibus_addr_o SHALL hold until ibus_ack_i=1.
REQ-019 On ack in WAIT with flush=0, the FSM SHALL push {ibus_addr_o, ibus_rdata_i}, clear ibus_req_o and return to IDLE.
REQ-020 On ack in WAIT with flush=1, the FSM SHALL discard the data, clear ibus_req_o and return to IDLE.
REQ-021 In WAIT with flush=1 and ack=0, the FSM SHALL go to DRAIN with the request still held.
REQ-022 In DRAIN, on ack the FSM SHALL discard the data, clear ibus_req_o and return to IDLE; flush in DRAIN has no further effect.
REQ-023 stallreq_o SHALL be combinational and equal to ce_i AND NOT (state==WAIT AND ibus_ack_i AND NOT flush), so the PC advances only in the cycle its word is captured.
REQ-024 Minimum cost is 2 cycles per instruction: pc_i is sampled in IDLE, the request is visible the next cycle, and ack may arrive in that same cycle.
REQ-025 if_valid_o SHALL be 1 iff count>0; if_pc_o and if_inst_o SHALL be the FIFO head, driven combinationally from storage.
REQ-026 A pop SHALL occur at the clock edge when if_valid_o=1, stall[1]=0 and flush=0.
REQ-027 A simultaneous push and pop SHALL leave count unchanged.
REQ-028 Push while count==4 SHALL be impossible, because no request is issued when count==4.
REQ-029 flush=1 SHALL set count, read pointer and write pointer to 0 at the next edge, with no pop.
REQ-030 Pointers SHALL be 2 bits and wrap modulo 4; count SHALL be 3 bits in the range 0..4.
REQ-031 With ce_i=0, no new request SHALL be issued; an in-flight request SHALL still complete normally.

Reset
REQ-032 With rst=1 at an edge: state<=IDLE, ibus_req_o<=0, ibus_addr_o<=0, count and pointers<=0; consequently if_valid_o=0, if_pc_o=0 and if_inst_o=0.
REQ-033 Reset SHALL abandon any outstanding bus request immediately; a late ack arriving in IDLE SHALL be ignored.
REQ-034 stallreq_o SHALL follow REQ-023 during reset; ctrl gates it.

Structure
REQ-035 defines.v SHALL hold the FSM state encodings, `IFBufDepth (4), `IFBufPtrBus and the stall-bit index macros; the block uses the existing `ZeroWord, `InstAddrBus and `InstBus.
REQ-036 FIFO storage, pointers and count SHALL live in one sub-module, inst_fifo; the FSM and stallreq logic stay in the top.

Verification
REQ-037 Zero-wait bus (ack on every request cycle), pc_i stepping 0x0,0x4,0x8 with stall[1]=0 -> if_pc_o sequence 0x0,0x4,0x8, a new entry every 2 cycles, stallreq_o alternating 1,0.
REQ-038 stall[1]=1 held while 5 fetches are attempted -> count saturates at 4, ibus_req_o stays 0 and stallreq_o stays 1; release -> the head pops 0x0 next.
REQ-039 flush in WAIT, ack 3 cycles later -> state is DRAIN, the ack data (0xDEADBEEF) is not pushed and if_valid_o=0.
REQ-040 flush coincident with ack in WAIT -> nothing is pushed, stallreq_o=1 and state returns to IDLE.
REQ-041 rst asserted while WAIT with 2 entries buffered -> next cycle ibus_req_o=0, if_valid_o=0 and if_inst_o=0; a subsequent stray ack is ignored.
REQ-042 Simultaneous push and pop at count=2 -> count remains 2 and order is preserved.
